// File: rtl/alu_defs.vh
// Shared opcode and state encodings for the ALU / multiply-divide block.
// Wrapped in a package behind an include guard, so every file can include
// it and then import alu_defs::*.
`ifndef ALU_DEFS_VH
`define ALU_DEFS_VH

package alu_defs;

    // Combinational ALU opcodes (ctl)
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

    // Multiply/divide opcodes (md_op); 3'b111 is reserved and means "none"
    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    // Iterative engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

endpackage

`endif

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one result bit per cycle on operand
// magnitudes, then a single FIX cycle applies signs and loads hi/lo.
// The divider is only compiled in when ALU_MULDIV_DIV_EN is defined;
// otherwise DIV/DIVU are ignored like any other no-op code.
`include "alu_defs.vh"

module muldiv_iter
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // p_hi/p_lo: product (mul) or remainder/quotient-shifter (div)
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [WIDTH-1:0] mcand_q, mcand_d;
    // product / quotient must be negated in FIX
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef ALU_MULDIV_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
`endif

    logic             accept_mul;
    logic             accept_div;
    logic             signed_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] res_hi, res_lo;

    // Two's-complement magnitude when the operation is signed
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Decode which operation (if any) is accepted on this edge
    always_comb begin
        signed_op  = (md_op == MD_MULT) || (md_op == MD_DIV);
        accept_mul = start && (state_q == ST_IDLE) &&
                     ((md_op == MD_MULT) || (md_op == MD_MULTU));
        accept_div = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        accept_div = start && (state_q == ST_IDLE) &&
                     ((md_op == MD_DIV) || (md_op == MD_DIVU));
`endif
    end

    // One iteration: shift-add multiply step or restoring divide step
    always_comb begin
        mul_sum = {1'b0, p_hi_q} + {1'b0, mcand_q};
        if (p_lo_q[0]) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], p_lo_q[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, p_hi_q[WIDTH-1:1]};
            step_lo = {p_hi_q[0], p_lo_q[WIDTH-1:1]};
        end
`ifdef ALU_MULDIV_DIV_EN
        div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        if (is_div_q) begin
            step_hi = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
            step_lo = {p_lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Sign correction of the magnitude result, applied in FIX
    always_comb begin
        prod     = {p_hi_q, p_lo_q};
        prod_fix = neg_q ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        if (is_div_q) begin
            if (div0_q) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = neg_rem_q ? -p_hi_q : p_hi_q;
                res_lo = neg_q ? -p_lo_q : p_lo_q;
            end
        end
`endif
    end

    // Next-state and register-update logic of the engine FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_d       = a_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_mul) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    p_hi_d  = '0;
                    p_lo_d  = mag(b, signed_op);
                    mcand_d = mag(a, signed_op);
                    neg_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MULDIV_DIV_EN
                    is_div_d = 1'b0;
`endif
                end
`ifdef ALU_MULDIV_DIV_EN
                else if (accept_div) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    p_hi_d    = '0;
                    p_lo_d    = mag(a, signed_op);
                    mcand_d   = mag(b, signed_op);
                    neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = signed_op && a[WIDTH-1];
                    div0_d    = (b == '0);
                    a_d       = a;
                    is_div_d  = 1'b1;
                end
`endif
                else if (start && (md_op == MD_MTHI)) begin
                    hi_d = a;
                end else if (start && (md_op == MD_MTLO)) begin
                    lo_d = a;
                end
            end
            ST_RUN: begin
                p_hi_d = step_hi;
                p_lo_d = step_lo;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_q       <= a_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// Combinational ALU plus an iterative multiply/divide unit with hi/lo
// result registers. Define ALU_MULDIV_DIV_EN to build in DIV/DIVU.
`include "alu_defs.vh"

module alu_muldiv
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             oflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] sum_w, diff_w, alu_res;
    logic             add_ovf, sub_ovf, slt, oflow_w;

    // Combinational ALU; slt uses the sub sign corrected by overflow
    always_comb begin
        sum_w   = a + b;
        diff_w  = a - b;
        add_ovf = (a[M] == b[M]) && (sum_w[M] != a[M]);
        sub_ovf = (a[M] != b[M]) && (diff_w[M] != a[M]);
        slt     = diff_w[M] ^ sub_ovf;
        alu_res = '0;
        oflow_w = 1'b0;
        case (ctl)
            CTL_ADD: begin
                alu_res = sum_w;
                oflow_w = add_ovf;
            end
            CTL_SUB: begin
                alu_res = diff_w;
                oflow_w = sub_ovf;
            end
            CTL_AND: alu_res = a & b;
            CTL_OR:  alu_res = a | b;
            CTL_NOR: alu_res = ~(a | b);
            CTL_XOR: alu_res = a ^ b;
            CTL_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = '0;
        endcase
    end

    assign out   = alu_res;
    assign z     = (alu_res == '0);
    assign oflow = oflow_w;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (WIDTH=32): directed and random ALU and
// multiply/divide operations compared with an arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [3:0]   ctl;
    logic [W-1:0] a, b;
    logic [2:0]   md_op;
    logic         start;
    logic [W-1:0] out, hi, lo;
    logic         z, oflow, busy, done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl),
        .a     (a),
        .b     (b),
        .md_op (md_op),
        .start (start),
        .out   (out),
        .z     (z),
        .oflow (oflow),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    // Reference ALU: plain signed/unsigned arithmetic
    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        case (c)
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b1100: return ~(x | y);
            4'b1101: return x ^ y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r, maxs, mins;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxs = (64'sd1 <<< 31) - 64'sd1;
        mins = -(64'sd1 <<< 31);
        if (c == 4'b0010)      r = sx + sy;
        else if (c == 4'b0110) r = sx - sy;
        else                   return 1'b0;
        return (r > maxs) || (r < mins);
    endfunction

    // Reference multiply/divide: returns {hi, lo}
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            3'b001: p = 64'(sx * sy);
            3'b010: p = ux * uy;
            3'b011, 3'b100: begin
                if (y == '0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (op == 3'b011) begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {ux % uy, ux / uy} ;
                    p = {(x % y), (x / y)};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Issue one multiply/divide and check latency, done pulse and results
    task automatic run_md(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [63:0] want;
        int cyc;
        want  = ref_md(op, x, y);
        md_op = op;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        md_op = 3'($urandom_range(0, 7));
        cyc   = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'(W + 1));
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, want[63:32]});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, want[31:0]});
        m_hi = want[63:32];
        m_lo = want[31:0];
        tick();
        check({tag, " done_clear"}, {63'd0, done}, 64'd0);
        $display("md op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", op, x, y, hi, lo, cyc);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] c;
        logic [W-1:0] x, y;
        int n_done;

        reset = 1'b1;
        start = 1'b0;
        ctl   = 4'd0;
        a     = '0;
        b     = '0;
        md_op = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);

        // Directed sub/slt at the signed boundary
        ctl = 4'b0110; a = 32'h8000_0000; b = 32'd1;
        #1;
        check("sub out", {32'd0, out}, 64'h7FFF_FFFF);
        check("sub oflow", {63'd0, oflow}, 64'd1);
        check("sub z", {63'd0, z}, 64'd0);
        ctl = 4'b0111;
        #1;
        check("slt out", {32'd0, out}, 64'd1);
        $display("alu ctl=0110/0111 a=80000000 b=1 -> checked");

        // Random ALU operations
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            x = pick_operand();
            y = pick_operand();
            ctl = c; a = x; b = y;
            #1;
            check("alu out", {32'd0, out}, {32'd0, ref_alu(c, x, y)});
            check("alu z", {63'd0, z}, {63'd0, (ref_alu(c, x, y) == '0)});
            check("alu oflow", {63'd0, oflow}, {63'd0, ref_ovf(c, x, y)});
            $display("alu ctl=%b a=%h b=%h -> out=%h z=%b oflow=%b", c, x, y, out, z, oflow);
        end

        // Multiply: directed then random
        run_md(3'b001, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        run_md(3'b001, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
        run_md(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        for (int i = 0; i < 4; i++) begin
            run_md(3'b001, pick_operand(), pick_operand(), "mult_rnd");
            run_md(3'b010, pick_operand(), pick_operand(), "multu_rnd");
        end

`ifdef ALU_MULDIV_DIV_EN
        run_md(3'b011, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_md(3'b100, 32'd7, 32'd0, "divu_zero");
        run_md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg1");
        run_md(3'b011, 32'hFFFF_FFF0, 32'd0, "div_zero_neg");
        for (int i = 0; i < 4; i++) begin
            run_md(3'b011, pick_operand(), $urandom, "div_rnd");
            run_md(3'b100, $urandom, pick_operand(), "divu_rnd");
        end
`else
        // Divide not built: DIV/DIVU must behave like no-ops
        md_op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        md_op = 3'b100;
        tick();
        start = 1'b0;
        check("div_off busy", {63'd0, busy}, 64'd0);
        check("div_off done", {63'd0, done}, 64'd0);
        check("div_off hi", {32'd0, hi}, {32'd0, m_hi});
        check("div_off lo", {32'd0, lo}, {32'd0, m_lo});
        $display("div disabled: DIV/DIVU ignored hi=%h lo=%h", hi, lo);
`endif

        // None and reserved codes do nothing
        md_op = 3'b000; start = 1'b1;
        tick();
        md_op = 3'b111;
        tick();
        start = 1'b0;
        check("nop busy", {63'd0, busy}, 64'd0);
        check("nop hi", {32'd0, hi}, {32'd0, m_hi});
        $display("md none/reserved -> busy=%b", busy);

        // Second start while busy, plus MTHI while busy, are ignored
        md_op = 3'b010; a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        md_op = 3'b010; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        md_op = 3'b101; a = 32'hDEAD;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("busy_start done_count", 64'(n_done), 64'd1);
        check("busy_start lo", {32'd0, lo}, 64'd30);
        check("busy_start hi", {32'd0, hi}, 64'd0);
        m_hi = '0;
        m_lo = 32'd30;
        $display("multu 5x6 with restart -> hi=%h lo=%h dones=%0d", hi, lo, n_done);

        // MTHI / MTLO in IDLE
        md_op = 3'b101; a = 32'hCAFE_0001; start = 1'b1;
        tick();
        start = 1'b0;
        check("mthi hi", {32'd0, hi}, 64'hCAFE_0001);
        check("mthi busy", {63'd0, busy}, 64'd0);
        md_op = 3'b110; a = 32'hBEEF_0002; start = 1'b1;
        tick();
        start = 1'b0;
        check("mtlo lo", {32'd0, lo}, 64'hBEEF_0002);
        check("mtlo done", {63'd0, done}, 64'd0);
        check("mtlo hi_kept", {32'd0, hi}, 64'hCAFE_0001);
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);

        // Reset in the middle of RUN, with a start during reset
        md_op = 3'b001; a = 32'h1234_5678; b = 32'h0000_0F0F; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1; start = 1'b1; md_op = 3'b110; a = 32'h5555;
        tick();
        reset = 1'b0; start = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("abort no_done", 64'(n_done), 64'd0);
        md_op = 3'b101; a = 32'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset mthi", {32'd0, hi}, 64'h1234);
        check("post_reset lo", {32'd0, lo}, 64'd0);
        $display("reset mid-run then mthi -> hi=%h lo=%h dones=%0d", hi, lo, n_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
